// File: rtl/ic_cpu_bus_arbiter.sv
// ic_cpu_bus_arbiter
//   Shares one downstream CPU bus between two requesters: m0 (instruction
//   fetch) and m1 (load/store). Requests are arbitrated round-robin, each
//   accepted request pushes its requester ID into an in-order FIFO, and each
//   downstream response is routed back to the requester at the FIFO head.
//
// Parameters
//   DEPTH      maximum outstanding accepted-but-unanswered transactions
//              (power of 2, >= 2)
//   PRIO_INIT  requester favoured first after reset (0 = m0, 1 = m1)
//
// Ports
//   g_clk, g_resetn          clock, asynchronous active-low reset
//   mN_req/gnt               requester N request handshake
//   mN_wen/strb/wdata/addr   requester N request fields
//   mN_recv/ack              requester N response handshake
//   mN_error/rdata           response fields (broadcast to both requesters)
//   s_req/gnt                downstream request handshake
//   s_wen/strb/wdata/addr    downstream request fields
//   s_recv/ack               downstream response handshake
//   s_error/rdata            downstream response fields
//   err_orphan               sticky: response arrived with nothing outstanding
module ic_cpu_bus_arbiter #(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        m0_req,
    output logic        m0_gnt,
    input  logic        m0_wen,
    input  logic [3:0]  m0_strb,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m0_addr,
    output logic        m0_recv,
    input  logic        m0_ack,
    output logic        m0_error,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    output logic        m1_gnt,
    input  logic        m1_wen,
    input  logic [3:0]  m1_strb,
    input  logic [31:0] m1_wdata,
    input  logic [31:0] m1_addr,
    output logic        m1_recv,
    input  logic        m1_ack,
    output logic        m1_error,
    output logic [31:0] m1_rdata,

    output logic        s_req,
    input  logic        s_gnt,
    output logic        s_wen,
    output logic [3:0]  s_strb,
    output logic [31:0] s_wdata,
    output logic [31:0] s_addr,
    input  logic        s_recv,
    output logic        s_ack,
    input  logic        s_error,
    input  logic [31:0] s_rdata,

    output logic        err_orphan
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } req_id_t;

    localparam req_id_t RR_INIT = (PRIO_INIT != 0) ? M1 : M0;

    // Arbitration state
    logic    r_lock;
    req_id_t r_lock_id;
    req_id_t r_rr;
    logic    r_orphan;

    // Outstanding-ID FIFO
    req_id_t       r_fifo [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;

    req_id_t w_sel;
    req_id_t w_head;
    logic    w_full;
    logic    w_empty;
    logic    w_sel_req;
    logic    w_push;
    logic    w_pop;
    logic    w_head_ack;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd];

    // A locked (issued but not yet granted) request keeps the bus so its
    // fields stay stable; otherwise a lone requester wins, and a tie goes to rr.
    always_comb begin
        w_sel = r_rr;
        if (r_lock) begin
            w_sel = r_lock_id;
        end else if (m0_req && !m1_req) begin
            w_sel = M0;
        end else if (m1_req && !m0_req) begin
            w_sel = M1;
        end
    end

    assign w_sel_req = (w_sel == M1) ? m1_req : m0_req;

    assign s_req   = w_sel_req && !w_full;
    assign s_wen   = (w_sel == M1) ? m1_wen   : m0_wen;
    assign s_strb  = (w_sel == M1) ? m1_strb  : m0_strb;
    assign s_wdata = (w_sel == M1) ? m1_wdata : m0_wdata;
    assign s_addr  = (w_sel == M1) ? m1_addr  : m0_addr;

    assign w_push = s_req && s_gnt;
    assign m0_gnt = w_push && (w_sel == M0);
    assign m1_gnt = w_push && (w_sel == M1);

    // With nothing outstanding any response is an orphan and is consumed.
    assign w_head_ack = (w_head == M1) ? m1_ack : m0_ack;
    assign s_ack      = w_empty ? 1'b1 : w_head_ack;
    assign w_pop      = s_recv && s_ack && !w_empty;

    assign m0_recv  = s_recv && !w_empty && (w_head == M0);
    assign m1_recv  = s_recv && !w_empty && (w_head == M1);
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign m0_error = s_error;
    assign m1_error = s_error;

    assign err_orphan = r_orphan;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_lock    <= 1'b0;
            r_lock_id <= M0;
            r_rr      <= RR_INIT;
            r_orphan  <= 1'b0;
        end else begin
            if (w_push) begin
                r_lock <= 1'b0;
                r_rr   <= (w_sel == M1) ? M0 : M1;
            end else if (s_req) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
            if (s_recv && w_empty) begin
                r_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= M0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr] <= w_sel;
                r_wr         <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ic_cpu_bus_arbiter.sv
module tb_ic_cpu_bus_arbiter;

    logic        g_clk;
    logic        g_resetn;
    logic        m0_req, m0_gnt, m0_wen, m0_recv, m0_ack, m0_error;
    logic [3:0]  m0_strb;
    logic [31:0] m0_wdata, m0_addr, m0_rdata;
    logic        m1_req, m1_gnt, m1_wen, m1_recv, m1_ack, m1_error;
    logic [3:0]  m1_strb;
    logic [31:0] m1_wdata, m1_addr, m1_rdata;
    logic        s_req, s_gnt, s_wen, s_recv, s_ack, s_error;
    logic [3:0]  s_strb;
    logic [31:0] s_wdata, s_addr, s_rdata;
    logic        err_orphan;

    int checks = 0;
    int errors = 0;

    ic_cpu_bus_arbiter #(.DEPTH(2), .PRIO_INIT(0)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_wen(m0_wen), .m0_strb(m0_strb),
        .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_recv(m0_recv), .m0_ack(m0_ack),
        .m0_error(m0_error), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_wen(m1_wen), .m1_strb(m1_strb),
        .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_recv(m1_recv), .m1_ack(m1_ack),
        .m1_error(m1_error), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
        .s_wdata(s_wdata), .s_addr(s_addr), .s_recv(s_recv), .s_ack(s_ack),
        .s_error(s_error), .s_rdata(s_rdata),
        .err_orphan(err_orphan)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    typedef struct {
        bit          rst;
        logic        r0, r1, gnt, recv, a0, a1;
        logic [31:0] rdata;
        logic        e_g0, e_g1, e_sreq;
        logic [31:0] e_addr;
        logic        e_rv0, e_rv1, e_sack, e_orph;
    } vec_t;

    typedef struct {
        bit          id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  ctl;
    } txn_t;

    vec_t        vecs[$];
    bit          sb_id[$];
    txn_t        sb[$];
    logic [31:0] dsq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rst, logic r0, logic r1, logic gnt, logic recv,
                                logic a0, logic a1, logic [31:0] rdata,
                                logic g0, logic g1, logic sreq, logic [31:0] addr,
                                logic rv0, logic rv1, logic sack, logic orph);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.gnt = gnt; v.recv = recv;
        v.a0 = a0; v.a1 = a1; v.rdata = rdata;
        v.e_g0 = g0; v.e_g1 = g1; v.e_sreq = sreq; v.e_addr = addr;
        v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_sack = sack; v.e_orph = orph;
        return v;
    endfunction

    task automatic idle_inputs();
        m0_req = 0; m0_wen = 0; m0_strb = '0; m0_wdata = '0; m0_addr = '0; m0_ack = 0;
        m1_req = 0; m1_wen = 0; m1_strb = '0; m1_wdata = '0; m1_addr = '0; m1_ack = 0;
        s_gnt = 0; s_recv = 0; s_error = 0; s_rdata = '0;
    endtask

    // Leaves the bench at a negedge with reset released.
    task automatic do_reset();
        idle_inputs();
        g_resetn = 1'b0;
        @(negedge g_clk);
        @(negedge g_clk);
        g_resetn = 1'b1;
        sb_id.delete();
    endtask

    logic        p0, p1;
    logic [31:0] a0q, a1q, w0q, w1q;
    txn_t        t;

    initial begin
        g_resetn = 1'b0;
        idle_inputs();

        // Single m0 read with next-cycle response
        vecs.push_back(mk(1, 1,0,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 1,0, 32'hDEADBEEF,   0,0,0, 32'h0,   1,0,1,0));
        // Both requesting continuously: m0, m1, m0, m1 with in-order routing
        vecs.push_back(mk(1, 1,1,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 1,1,1,1, 1,0, 32'h11111111,   0,1,1, 32'h200, 1,0,1,0));
        vecs.push_back(mk(0, 1,1,1,1, 0,1, 32'h22222222,   1,0,1, 32'h100, 0,1,1,0));
        vecs.push_back(mk(0, 1,1,1,1, 1,0, 32'h33333333,   0,1,1, 32'h200, 1,0,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,1, 32'h44444444,   0,0,0, 32'h0,   0,1,1,0));
        // m1 stalled by s_gnt = 0 holds the bus; m0 waits
        vecs.push_back(mk(1, 0,1,0,0, 0,0, 32'h0,          0,0,1, 32'h200, 0,0,1,0));
        vecs.push_back(mk(0, 1,1,0,0, 0,0, 32'h0,          0,0,1, 32'h200, 0,0,1,0));
        vecs.push_back(mk(0, 1,1,0,0, 0,0, 32'h0,          0,0,1, 32'h200, 0,0,1,0));
        vecs.push_back(mk(0, 1,1,1,0, 0,0, 32'h0,          0,1,1, 32'h200, 0,0,1,0));
        vecs.push_back(mk(0, 1,0,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,1, 32'h55555555,   0,0,0, 32'h0,   0,1,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 1,0, 32'h66666666,   0,0,0, 32'h0,   1,0,1,0));
        // DEPTH = 2: third request blocked while full, granted once a slot is free
        vecs.push_back(mk(1, 1,0,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 1,0,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 1,0,1,0, 0,0, 32'h0,          0,0,0, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 1,0,1,1, 1,0, 32'h77777777,   0,0,0, 32'h100, 1,0,1,0));
        vecs.push_back(mk(0, 1,0,1,1, 1,0, 32'h88888888,   1,0,1, 32'h100, 1,0,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 1,0, 32'h99999999,   0,0,0, 32'h0,   1,0,1,0));
        // Response stall by m0, then orphan response
        vecs.push_back(mk(1, 1,0,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,1, 32'hAAAAAAAA,   0,0,0, 32'h0,   1,0,0,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,1, 32'hAAAAAAAA,   0,0,0, 32'h0,   1,0,0,0));
        vecs.push_back(mk(0, 0,0,0,1, 1,0, 32'hAAAAAAAA,   0,0,0, 32'h0,   1,0,1,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0, 32'h0,          0,0,0, 32'h0,   0,0,1,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,0, 32'hBBBBBBBB,   0,0,0, 32'h0,   0,0,1,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0, 32'h0,          0,0,0, 32'h0,   0,0,1,1));
        vecs.push_back(mk(0, 1,0,1,0, 0,0, 32'h0,          1,0,1, 32'h100, 0,0,1,1));

        // Reset state
        @(negedge g_clk);
        do_reset();
        #1;
        chk("reset m0_gnt", m0_gnt, 0);
        chk("reset m1_gnt", m1_gnt, 0);
        chk("reset s_req", s_req, 0);
        chk("reset m0_recv", m0_recv, 0);
        chk("reset m1_recv", m1_recv, 0);
        chk("reset err_orphan", err_orphan, 0);
        chk("reset s_addr", s_addr, 0);
        @(negedge g_clk);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            m0_req = vecs[k].r0; m0_addr = 32'h100;
            m1_req = vecs[k].r1; m1_addr = 32'h200;
            s_gnt = vecs[k].gnt; s_recv = vecs[k].recv; s_rdata = vecs[k].rdata;
            m0_ack = vecs[k].a0; m1_ack = vecs[k].a1;
            #1;
            chk($sformatf("v%0d m0_gnt", k), m0_gnt, vecs[k].e_g0);
            chk($sformatf("v%0d m1_gnt", k), m1_gnt, vecs[k].e_g1);
            chk($sformatf("v%0d s_req", k), s_req, vecs[k].e_sreq);
            if (vecs[k].e_sreq) chk($sformatf("v%0d s_addr", k), s_addr, vecs[k].e_addr);
            chk($sformatf("v%0d m0_recv", k), m0_recv, vecs[k].e_rv0);
            chk($sformatf("v%0d m1_recv", k), m1_recv, vecs[k].e_rv1);
            if (vecs[k].recv) begin
                chk($sformatf("v%0d s_ack", k), s_ack, vecs[k].e_sack);
                chk($sformatf("v%0d m0_rdata", k), m0_rdata, vecs[k].rdata);
                chk($sformatf("v%0d m1_rdata", k), m1_rdata, vecs[k].rdata);
            end
            chk($sformatf("v%0d err_orphan", k), err_orphan, vecs[k].e_orph);
            // Scoreboard: pop on expected response transfer, push on expected grant
            if (vecs[k].recv && vecs[k].e_sack && (vecs[k].e_rv0 || vecs[k].e_rv1)) begin
                if (sb_id.size() == 0) begin
                    chk($sformatf("v%0d sb underflow", k), 1, 0);
                end else begin
                    bit id;
                    id = sb_id.pop_front();
                    chk($sformatf("v%0d route", k), {30'd0, m1_recv, m0_recv}, id ? 32'd2 : 32'd1);
                end
            end
            if (vecs[k].e_g0) sb_id.push_back(1'b0);
            if (vecs[k].e_g1) sb_id.push_back(1'b1);
            @(negedge g_clk);
        end

        // Async reset mid-stream: clears err_orphan without a clock edge and
        // drops the outstanding ID left by the last vector.
        m0_req = 0;
        #2 g_resetn = 1'b0;
        #1;
        chk("async rst err_orphan", err_orphan, 0);
        chk("async rst s_req", s_req, 0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        s_recv = 1'b1; s_rdata = 32'h12345678; m0_ack = 1'b0;
        #1;
        chk("post-rst m0_recv", m0_recv, 0);
        chk("post-rst s_ack", s_ack, 1);
        @(negedge g_clk);
        s_recv = 1'b0;
        #1;
        chk("post-rst err_orphan", err_orphan, 1);

        // Randomised traffic with an in-order downstream model
        do_reset();
        p0 = 0; p1 = 0; a0q = '0; a1q = '0; w0q = '0; w1q = '0;
        sb.delete(); dsq.delete();
        for (int n = 0; n < 400; n++) begin
            if (!p0 && n < 300 && $urandom_range(0, 2) != 0) begin
                p0 = 1; a0q = $urandom; w0q = $urandom;
            end
            if (!p1 && n < 300 && $urandom_range(0, 2) != 0) begin
                p1 = 1; a1q = $urandom; w1q = $urandom;
            end
            m0_req = p0; m0_addr = a0q; m0_wdata = w0q; m0_wen = a0q[0]; m0_strb = a0q[7:4];
            m1_req = p1; m1_addr = a1q; m1_wdata = w1q; m1_wen = a1q[0]; m1_strb = a1q[7:4];
            s_gnt  = ($urandom_range(0, 3) != 0);
            m0_ack = ($urandom_range(0, 3) != 0);
            m1_ack = ($urandom_range(0, 3) != 0);
            if (dsq.size() > 0 && $urandom_range(0, 2) != 0) begin
                s_recv = 1'b1; s_rdata = ~dsq[0];
            end else begin
                s_recv = 1'b0; s_rdata = $urandom;
            end
            #1;
            if (m0_gnt && m1_gnt) chk("rand double gnt", 1, 0);
            if (s_recv && s_ack) begin
                if (sb.size() == 0) begin
                    chk("rand sb underflow", 1, 0);
                end else begin
                    t = sb.pop_front();
                    chk("rand route", {30'd0, m1_recv, m0_recv}, t.id ? 32'd2 : 32'd1);
                    chk("rand rdata", t.id ? m1_rdata : m0_rdata, ~t.addr);
                end
                void'(dsq.pop_front());
            end
            if (m0_gnt) begin
                t.id = 0; t.addr = a0q; t.wdata = w0q; t.ctl = {a0q[0], a0q[7:4]};
                sb.push_back(t); p0 = 0;
            end
            if (m1_gnt) begin
                t.id = 1; t.addr = a1q; t.wdata = w1q; t.ctl = {a1q[0], a1q[7:4]};
                sb.push_back(t); p1 = 0;
            end
            if (m0_gnt || m1_gnt) begin
                chk("rand s_addr", s_addr, sb[$].addr);
                chk("rand s_wdata", s_wdata, sb[$].wdata);
                chk("rand s_wen/strb", {27'd0, s_wen, s_strb}, {27'd0, sb[$].ctl});
            end
            if (s_req && s_gnt) dsq.push_back(s_addr);
            @(negedge g_clk);
        end
        chk("rand drained", sb.size(), 0);
        chk("rand pending", {30'd0, p1, p0}, 0);
        chk("rand err_orphan", err_orphan, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
